// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 inverse cipher: one inverse round per clock over a single 128-bit state register.
// Round keys are read combinationally from an external store addressed by key_idx.
module aes_inv_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [0:127]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  output logic              busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [KIDX_W-1:0] KEY_LAST   = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] ROUND_LOAD = KIDX_W'(NR - 1);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // a^254 is the field inverse (and maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  logic [1:0]        fsm_q, fsm_d;
  logic [KIDX_W-1:0] round_q, round_d;
  logic [0:127]      state_q, state_d;
  logic [0:127]      isr_isb, ark, imc;
  logic              accept;

  assign in_ready  = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q == S_ROUND) | (fsm_q == S_FINAL);
  assign out_data  = state_q;

  always_comb begin
    case (fsm_q)
      S_ROUND: key_idx = round_q;
      S_FINAL: key_idx = '0;
      default: key_idx = KEY_LAST;
    endcase
  end

  // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r.
  always_comb begin
    isr_isb = '0;
    imc     = '0;
    for (int i = 0; i < 16; i++)
      isr_isb[8*i +: 8] = inv_sbox(state_q[8*(4*(((i/4) - (i%4) + 4) % 4) + (i%4)) +: 8]);
    ark = isr_isb ^ round_key;
    for (int c = 0; c < 4; c++)
      imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    case (fsm_q)
      S_ROUND: begin
        state_d = imc;
        round_d = round_q - KIDX_W'(1);
        if (round_q == KIDX_W'(1)) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        state_d = ark;
        fsm_d   = S_DONE;
      end
      S_DONE: if (!out_ready) fsm_d = S_DONE;
              else if (!in_valid) fsm_d = S_IDLE;
      default: ;
    endcase
    // IDLE and DONE share the load path so a waiting block follows the output with no bubble
    if (accept) begin
      state_d = in_data ^ round_key;
      round_d = ROUND_LOAD;
      fsm_d   = S_ROUND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: transaction-level AES decrypt model plus FIPS-197 literal vectors.
module tb_aes_inv_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] in_data, round_key, out_data;
  logic [3:0]   key_idx;

  int total = 0;
  int bad   = 0;
  int key_sel = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isb  [256];
  logic [0:127] keys [0:1][0:10];

  localparam logic [0:127] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  assign round_key = (key_idx <= 4'd10) ? keys[key_sel][key_idx] : '0;

  aes_inv_round_ctrl #(.NR(10), .KIDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // polynomial product followed by reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isb[s]  = 8'(x);
    end
  endtask

  task automatic expand(input logic [0:127] key, input int ks);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) keys[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Straight FIPS-197 InvCipher on a byte-grid view of the block.
  function automatic logic [0:127] decrypt(input logic [0:127] ct, input int ks);
    logic [7:0] g [4][4];
    logic [7:0] row [4];
    logic [7:0] col [4];
    logic [7:0] m [4][4];
    logic [0:127] x;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    x = ct ^ keys[ks][10];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) g[w][c] = x[32*c + 8*w +: 8];
      for (int w = 0; w < 4; w++) begin
        for (int c = 0; c < 4; c++) row[c] = g[w][c];
        for (int c = 0; c < 4; c++) g[w][(c + w) % 4] = isb[row[c]];
      end
      for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) x[32*c + 8*w +: 8] = g[w][c];
      x = x ^ keys[ks][r];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) col[w] = x[32*c + 8*w +: 8];
          for (int w = 0; w < 4; w++)
            x[32*c + 8*w +: 8] = gm(m[w][0], col[0]) ^ gm(m[w][1], col[1]) ^
                                 gm(m[w][2], col[2]) ^ gm(m[w][3], col[3]);
        end
    end
    return x;
  endfunction

  // Model: age 0 idle, 1..10 cycles into a block, 11 result waiting.
  int           m_age;
  logic [0:127] m_exp, m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= 0;
      m_exp  <= '0;
      m_last <= '0;
    end else if (m_age == 0 || (m_age == 11 && out_ready)) begin
      if (in_valid) begin
        m_age <= 1;
        m_exp <= decrypt(in_data, key_sel);
      end else begin
        m_age <= 0;
      end
    end else if (m_age <= 10) begin
      m_age <= m_age + 1;
      if (m_age == 10) m_last <= m_exp;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 128'(in_ready), 128'((m_age == 0) || (m_age == 11 && out_ready)));
      chk("out_valid", 128'(out_valid), 128'(m_age == 11));
      chk("busy", 128'(busy), 128'(m_age >= 1 && m_age <= 10));
      chk("key_idx", 128'(key_idx), 128'((m_age >= 1 && m_age <= 10) ? 10 - m_age : 10));
      if (m_age == 0)  chk("out_data_idle", out_data, m_last);
      if (m_age == 11) chk("out_data_done", out_data, m_exp);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      step(1);
      n++;
    end
    chk(nm, 128'(out_valid), 128'(1));
  endtask

  task automatic take();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({nm, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({nm, "_busy"}, 128'(busy), 128'(0));
    chk({nm, "_out_data"}, out_data, '0);
    chk({nm, "_key_idx"}, 128'(key_idx), 128'(10));
  endtask

  initial begin
    int gap;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    build_tables();
    expand(KEY_A, 0);
    expand(KEY_B, 1);
    chk("model_k10_a", keys[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_k10_b", keys[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_dec_a", decrypt(CT_A, 0), PT_A);
    chk("model_dec_b", decrypt(CT_B, 1), PT_B);
    #2 chk_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // T1/T2: FIPS C.1, exact latency and key index sequence
    key_sel = 0; in_data = CT_A; in_valid = 1'b1;
    chk("t2_key_accept", 128'(key_idx), 128'(10));
    step(1);
    in_valid = 1'b0;
    chk("t2_istart", out_data, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    for (int k = 0; k < 10; k++) begin
      chk("t2_key_seq", 128'(key_idx), 128'(9 - k));
      chk("t2_busy", 128'(busy), 128'(1));
      step(1);
    end
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_out_data", out_data, PT_A);
    chk("t2_busy_end", 128'(busy), 128'(0));
    take();
    chk("t1_drop", 128'(out_valid), 128'(0));

    // T3: FIPS App. B with output back-pressure
    key_sel = 1; in_data = CT_B; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_done("t3_done");
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 128'(out_valid), 128'(1));
      chk("t3_hold_data", out_data, PT_B);
      step(1);
    end
    take();

    // T4: back-to-back blocks, second accepted as the first is taken
    key_sel = 0; in_data = CT_A; in_valid = 1'b1; out_ready = 1'b1;
    step(1);
    in_data = CT_B;
    wait_done("t4_first_done");
    chk("t4_first_data", out_data, PT_A);
    chk("t4_in_ready", 128'(in_ready), 128'(1));
    key_sel = 1;
    step(1);
    in_valid = 1'b0;
    gap = 1;
    while (!out_valid && gap < 30) begin
      step(1);
      gap++;
    end
    chk("t4_gap", 128'(gap), 128'(11));
    chk("t4_second_data", out_data, PT_B);
    step(1);
    out_ready = 1'b0;

    // T5: garbage offered while busy is ignored
    key_sel = 0; in_data = CT_A; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(3);
    in_valid = 1'b1; in_data = 128'hdeadbeef_00000000_cafef00d_12345678;
    chk("t5_in_ready", 128'(in_ready), 128'(0));
    step(2);
    in_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_out_data", out_data, PT_A);
    take();

    // T6: asynchronous reset mid-block, then a clean decrypt
    in_data = CT_A; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    chk("t6_round5_key", 128'(key_idx), 128'(5));
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(posedge clk); #1 rst_n = 1'b1;
    in_data = CT_A; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_out_data", out_data, PT_A);
    take();
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
